// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl
//
// Sequences supervisor trap entry and SRET return. In IDLE it picks one
// request (exception > SRET > interrupt). It then drains the pipeline
// (FLUSH), issues a one-shot CSR write (WRITE), and hands the new PC to
// fetch (REDIRECT).
//
// Parameters
//   DRAIN_TIMEOUT : FLUSH cycles allowed before a forced advance (>= 2)
//   VEC_EN        : allow vectored interrupt targets when stvec[1:0] == 01
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   exc_valid/cause/tval/pc       synchronous exception (held until accept)
//   irq_pending[2:0]              {SEI, STI, SSI}
//   boundary, next_pc             instruction boundary and resume PC
//   sret_req                      SRET retiring (held until accept)
//   csr_stvec_q, csr_sepc_q       current stvec / sepc
//   sie_q, spie_q                 current sstatus.SIE / SPIE
//   pipe_drained                  pipeline empty
//   redirect_ready                fetch accepts redirect
//   accept                        pulse: request captured this cycle
//   flush                         kill/drain pipeline (FLUSH and WRITE)
//   trap_we / ret_we              one-cycle CSR write strobes
//   sepc_d, scause_d, stval_d,
//   sie_d, spie_d                 CSR write data (hold when no strobe)
//   redirect_valid, redirect_pc   redirect request to fetch
//   busy                          state != IDLE
//   drain_timeout                 pulse: FLUSH left on timeout
//
// Redirect handshake: redirect_valid is high for the whole REDIRECT state
// and redirect_pc is stable while it is high. The transfer happens on the
// clock edge where redirect_valid & redirect_ready are both high. On the
// next cycle the block is back in IDLE with redirect_valid low. Reset drops
// any redirect that has not yet been transferred.
// ---------------------------------------------------------------------------
module trap_ctrl #(
   parameter int DRAIN_TIMEOUT = 16,
   parameter bit VEC_EN        = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exc_valid,
   input  logic [4:0]  exc_cause,
   input  logic [31:0] exc_tval,
   input  logic [31:0] exc_pc,
   input  logic [2:0]  irq_pending,
   input  logic        boundary,
   input  logic [31:0] next_pc,
   input  logic        sret_req,
   input  logic [31:0] csr_stvec_q,
   input  logic [31:0] csr_sepc_q,
   input  logic        sie_q,
   input  logic        spie_q,
   input  logic        pipe_drained,
   input  logic        redirect_ready,
   output logic        accept,
   output logic        flush,
   output logic        trap_we,
   output logic        ret_we,
   output logic [31:0] sepc_d,
   output logic [31:0] scause_d,
   output logic [31:0] stval_d,
   output logic        sie_d,
   output logic        spie_d,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy,
   output logic        drain_timeout
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_FLUSH    = 2'd1,
      S_WRITE    = 2'd2,
      S_REDIRECT = 2'd3
   } state_t;

   typedef enum logic {
      K_TRAP = 1'b0,
      K_RET  = 1'b1
   } kind_t;

   localparam int             CW      = $clog2(DRAIN_TIMEOUT);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DRAIN_TIMEOUT - 1);

   state_t        state_q, state_d;
   kind_t         kind_q;
   logic [CW-1:0] cnt_q;

   // Captured at accept.
   logic [31:0]   cap_sepc_q;
   logic [31:0]   cap_cause_q;   // bit 31 = interrupt, [4:0] = code
   logic [31:0]   cap_tval_q;
   logic [31:0]   cap_ret_pc_q;  // csr_sepc_q sampled when SRET is taken

   // Last values written, so the data outputs hold between strobes.
   logic [31:0]   sepc_h_q, scause_h_q, stval_h_q;
   logic          sie_h_q, spie_h_q;
   logic [31:0]   redirect_pc_q;

   // ---------------- request selection ----------------
   logic       irq_take;
   logic [4:0] irq_code;
   logic       take;
   logic       drain_done;

   assign irq_take = boundary & sie_q & (|irq_pending);

   // Interrupt priority: SEI > SSI > STI.
   always_comb begin
      irq_code = 5'd0;
      if (irq_pending[2])      irq_code = 5'd9;
      else if (irq_pending[0]) irq_code = 5'd1;
      else if (irq_pending[1]) irq_code = 5'd5;
   end

   // Requests are only looked at in IDLE; sources hold them while busy.
   assign take       = (state_q == S_IDLE) & ~rst & (exc_valid | sret_req | irq_take);
   assign drain_done = pipe_drained | (cnt_q == CNT_MAX);

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (take) state_d = S_FLUSH;
         S_FLUSH:    if (drain_done) state_d = S_WRITE;
         S_WRITE:    state_d = S_REDIRECT;
         S_REDIRECT: if (redirect_ready) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // ---------------- capture and drain counter ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         kind_q       <= K_TRAP;
         cap_sepc_q   <= '0;
         cap_cause_q  <= '0;
         cap_tval_q   <= '0;
         cap_ret_pc_q <= '0;
      end else if (take) begin
         if (exc_valid) begin
            kind_q      <= K_TRAP;
            cap_sepc_q  <= exc_pc;
            cap_cause_q <= {1'b0, 26'b0, exc_cause};
            cap_tval_q  <= exc_tval;
         end else if (sret_req) begin
            kind_q       <= K_RET;
            cap_ret_pc_q <= csr_sepc_q;
         end else begin
            kind_q      <= K_TRAP;
            cap_sepc_q  <= next_pc;
            cap_cause_q <= {1'b1, 26'b0, irq_code};
            cap_tval_q  <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                    cnt_q <= '0;
      else if (take)              cnt_q <= '0;
      else if (state_q == S_FLUSH) cnt_q <= cnt_q + 1'b1;
   end

   // ---------------- target computation ----------------
   logic [31:0] trap_base;
   logic [31:0] vec_off;
   logic [31:0] target;

   assign trap_base = {csr_stvec_q[31:2], 2'b00};
   assign vec_off   = {25'b0, cap_cause_q[4:0], 2'b00};

   always_comb begin
      target = trap_base;
      if (kind_q == K_RET)
         target = {cap_ret_pc_q[31:1], 1'b0};
      else if (VEC_EN && (csr_stvec_q[1:0] == 2'b01) && cap_cause_q[31])
         target = trap_base + vec_off;   // 32-bit wrap is intended
   end

   always_ff @(posedge clk) begin
      if (rst)                     redirect_pc_q <= '0;
      else if (state_q == S_WRITE) redirect_pc_q <= target;
   end

   // ---------------- CSR write strobes and data ----------------
   logic write_trap, write_ret;
   logic sie_new, spie_new;

   assign write_trap = (state_q == S_WRITE) & (kind_q == K_TRAP);
   assign write_ret  = (state_q == S_WRITE) & (kind_q == K_RET);
   assign sie_new    = (kind_q == K_TRAP) ? 1'b0  : spie_q;
   assign spie_new   = (kind_q == K_TRAP) ? sie_q : 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         sepc_h_q   <= '0;
         scause_h_q <= '0;
         stval_h_q  <= '0;
         sie_h_q    <= 1'b0;
         spie_h_q   <= 1'b0;
      end else begin
         if (write_trap) begin
            sepc_h_q   <= cap_sepc_q;
            scause_h_q <= cap_cause_q;
            stval_h_q  <= cap_tval_q;
         end
         if (write_trap | write_ret) begin
            sie_h_q  <= sie_new;
            spie_h_q <= spie_new;
         end
      end
   end

   // ---------------- outputs ----------------
   assign accept         = take;
   assign flush          = (state_q == S_FLUSH) | (state_q == S_WRITE);
   assign trap_we        = write_trap;
   assign ret_we         = write_ret;
   assign sepc_d         = write_trap ? cap_sepc_q  : sepc_h_q;
   assign scause_d       = write_trap ? cap_cause_q : scause_h_q;
   assign stval_d        = write_trap ? cap_tval_q  : stval_h_q;
   assign sie_d          = (write_trap | write_ret) ? sie_new  : sie_h_q;
   assign spie_d         = (write_trap | write_ret) ? spie_new : spie_h_q;
   assign redirect_valid = (state_q == S_REDIRECT);
   assign redirect_pc    = redirect_pc_q;
   assign busy           = (state_q != S_IDLE);
   // No pulse when the pipe drains on the same cycle the count runs out.
   assign drain_timeout  = (state_q == S_FLUSH) & (cnt_q == CNT_MAX) & ~pipe_drained;

endmodule

// File: tb/tb_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl
//
// Directed bench for trap_ctrl. A table of single-transaction vectors runs
// first. Hand-written sequences then cover priority, drain timeout,
// redirect backpressure and reset during FLUSH.
// ---------------------------------------------------------------------------
module tb_trap_ctrl;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic        exc_valid;
   logic [4:0]  exc_cause;
   logic [31:0] exc_tval;
   logic [31:0] exc_pc;
   logic [2:0]  irq_pending;
   logic        boundary;
   logic [31:0] next_pc;
   logic        sret_req;
   logic [31:0] csr_stvec_q;
   logic [31:0] csr_sepc_q;
   logic        sie_q;
   logic        spie_q;
   logic        pipe_drained;
   logic        redirect_ready;
   logic        accept, flush, trap_we, ret_we;
   logic [31:0] sepc_d, scause_d, stval_d;
   logic        sie_d, spie_d;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        busy, drain_timeout;

   trap_ctrl #(.DRAIN_TIMEOUT(16), .VEC_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval), .exc_pc(exc_pc),
      .irq_pending(irq_pending), .boundary(boundary), .next_pc(next_pc),
      .sret_req(sret_req), .csr_stvec_q(csr_stvec_q), .csr_sepc_q(csr_sepc_q),
      .sie_q(sie_q), .spie_q(spie_q), .pipe_drained(pipe_drained),
      .redirect_ready(redirect_ready),
      .accept(accept), .flush(flush), .trap_we(trap_we), .ret_we(ret_we),
      .sepc_d(sepc_d), .scause_d(scause_d), .stval_d(stval_d),
      .sie_d(sie_d), .spie_d(spie_d),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .busy(busy), .drain_timeout(drain_timeout)
   );

   // ---------------- scoreboard counters ----------------
   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b, expected %b", name, act, exp);
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_src();
      exc_valid   = 1'b0;
      exc_cause   = 5'd0;
      exc_tval    = 32'h0;
      exc_pc      = 32'h0;
      irq_pending = 3'b000;
      boundary    = 1'b0;
      next_pc     = 32'h0;
      sret_req    = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk1({tag, "_accept"}, accept, 1'b0);
      chk1({tag, "_flush"}, flush, 1'b0);
      chk1({tag, "_trap_we"}, trap_we, 1'b0);
      chk1({tag, "_ret_we"}, ret_we, 1'b0);
      chk1({tag, "_rvalid"}, redirect_valid, 1'b0);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk1({tag, "_drain_to"}, drain_timeout, 1'b0);
      chk({tag, "_rpc"}, redirect_pc, 32'h0);
      chk({tag, "_sepc_d"}, sepc_d, 32'h0);
      chk({tag, "_scause_d"}, scause_d, 32'h0);
      chk({tag, "_stval_d"}, stval_d, 32'h0);
      chk1({tag, "_sie_d"}, sie_d, 1'b0);
      chk1({tag, "_spie_d"}, spie_d, 1'b0);
   endtask

   // Completes a REDIRECT already in progress: one handshake, then IDLE.
   task automatic finish_redirect();
      redirect_ready = 1'b1;
      step();
      redirect_ready = 1'b0;
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        exc_valid;
      logic [4:0]  exc_cause;
      logic [31:0] exc_pc;
      logic [31:0] exc_tval;
      logic [2:0]  irq;
      logic        boundary;
      logic [31:0] next_pc;
      logic        sret;
      logic [31:0] stvec;
      logic [31:0] sepc_q;
      logic        sie;
      logic        spie;
      logic        exp_accept;
      logic        exp_ret;
      logic [31:0] exp_sepc;
      logic [31:0] exp_scause;
      logic [31:0] exp_stval;
      logic        exp_sie;
      logic        exp_spie;
      logic [31:0] exp_rpc;
   } vec_t;

   vec_t vecs[9];

   task automatic run_vec(input vec_t v, input int idx);
      string t;
      t = $sformatf("v%0d", idx);
      exc_valid      = v.exc_valid;
      exc_cause      = v.exc_cause;
      exc_pc         = v.exc_pc;
      exc_tval       = v.exc_tval;
      irq_pending    = v.irq;
      boundary       = v.boundary;
      next_pc        = v.next_pc;
      sret_req       = v.sret;
      csr_stvec_q    = v.stvec;
      csr_sepc_q     = v.sepc_q;
      sie_q          = v.sie;
      spie_q         = v.spie;
      pipe_drained   = 1'b1;
      redirect_ready = 1'b0;
      #1;
      chk1({t, "_accept"}, accept, v.exp_accept);
      if (!v.exp_accept) begin
         step();
         chk1({t, "_idle_busy"}, busy, 1'b0);
         clear_src();
         return;
      end
      step();
      // Sources drop after accept; the captured cause must not follow them.
      clear_src();
      #1;
      chk1({t, "_flush"}, flush, 1'b1);
      chk1({t, "_accept_busy"}, accept, 1'b0);
      step();
      chk1({t, "_trap_we"}, trap_we, ~v.exp_ret);
      chk1({t, "_ret_we"}, ret_we, v.exp_ret);
      if (!v.exp_ret) begin
         chk({t, "_sepc_d"}, sepc_d, v.exp_sepc);
         chk({t, "_scause_d"}, scause_d, v.exp_scause);
         chk({t, "_stval_d"}, stval_d, v.exp_stval);
      end
      chk1({t, "_sie_d"}, sie_d, v.exp_sie);
      chk1({t, "_spie_d"}, spie_d, v.exp_spie);
      step();
      chk1({t, "_rvalid"}, redirect_valid, 1'b1);
      chk({t, "_rpc"}, redirect_pc, v.exp_rpc);
      finish_redirect();
      chk1({t, "_rvalid_done"}, redirect_valid, 1'b0);
      chk1({t, "_busy_done"}, busy, 1'b0);
   endtask

   // ---------------- drain sequence ----------------
   // drain_at: FLUSH cycle index where pipe_drained rises (-1 = never).
   task automatic run_flush(input int drain_at, input int exp_cycles,
                            input int exp_pulses, input int exp_pulse_at);
      int n, fc, tc, to_at;
      string t;
      t = $sformatf("drain%0d", drain_at);
      clear_src();
      pipe_drained = 1'b0;
      exc_valid    = 1'b1;
      exc_cause    = 5'd4;
      exc_pc       = 32'h800;
      csr_stvec_q  = 32'h3000_0000;
      #1;
      chk1({t, "_accept"}, accept, 1'b1);
      step();
      exc_valid = 1'b0;
      n = 0; fc = 0; tc = 0; to_at = -1;
      while (trap_we !== 1'b1 && n < 40) begin
         pipe_drained = (drain_at >= 0) && (n >= drain_at);
         #1;
         if (flush && !trap_we) fc++;
         if (drain_timeout) begin
            tc++;
            to_at = n;
         end
         step();
         n++;
      end
      chk1({t, "_reached_write"}, trap_we, 1'b1);
      chk({t, "_flush_cycles"}, fc, exp_cycles);
      chk({t, "_pulses"}, tc, exp_pulses);
      chk({t, "_pulse_at"}, to_at, exp_pulse_at);
      step();
      chk({t, "_rpc"}, redirect_pc, 32'h3000_0000);
      finish_redirect();
      pipe_drained = 1'b1;
   endtask

   // ---------------- main test ----------------
   initial begin
      int strobes;
      rst            = 1'b1;
      clear_src();
      csr_stvec_q    = 32'h0;
      csr_sepc_q     = 32'h0;
      sie_q          = 1'b0;
      spie_q         = 1'b0;
      pipe_drained   = 1'b1;
      redirect_ready = 1'b0;
      repeat (3) step();
      chk_all_zero("reset");
      rst = 1'b0;
      step();

      //            exc cause  exc_pc          exc_tval       irq     bnd   next_pc       sret  stvec          sepc_q         sie   spie  acc   ret   e_sepc        e_scause      e_stval       e_sie e_spie e_rpc
      vecs[0] = '{1'b1, 5'd2,  32'h0000_0100, 32'h0000_DEAD, 3'b000, 1'b0, 32'h0,        1'b0, 32'h8000_0001, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0002, 32'h0000_DEAD, 1'b0, 1'b1, 32'h8000_0000};
      vecs[1] = '{1'b0, 5'd0,  32'h0,         32'h0,         3'b110, 1'b1, 32'h0000_0204, 1'b0, 32'h8000_0001, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0204, 32'h8000_0009, 32'h0,         1'b0, 1'b1, 32'h8000_0024};
      vecs[2] = '{1'b0, 5'd0,  32'h0,         32'h0,         3'b000, 1'b0, 32'h0,        1'b1, 32'h8000_0001, 32'h0000_0303, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0,         32'h0,         32'h0,         1'b1, 1'b1, 32'h0000_0302};
      vecs[3] = '{1'b0, 5'd0,  32'h0,         32'h0,         3'b001, 1'b1, 32'h0000_0400, 1'b0, 32'h1000_0000, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h8000_0001, 32'h0,         1'b0, 1'b1, 32'h1000_0000};
      vecs[4] = '{1'b0, 5'd0,  32'h0,         32'h0,         3'b010, 1'b1, 32'h0000_0500, 1'b0, 32'hFFFF_FFF1, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'h8000_0005, 32'h0,         1'b0, 1'b1, 32'h0000_0004};
      vecs[5] = '{1'b0, 5'd0,  32'h0,         32'h0,         3'b100, 1'b1, 32'h0000_0600, 1'b0, 32'h8000_0001, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 32'h0};
      vecs[6] = '{1'b0, 5'd0,  32'h0,         32'h0,         3'b100, 1'b0, 32'h0000_0700, 1'b0, 32'h8000_0001, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 32'h0};
      vecs[7] = '{1'b1, 5'd31, 32'hFFFF_FFFC, 32'h0,         3'b111, 1'b1, 32'h0000_0800, 1'b0, 32'h0000_0103, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_001F, 32'h0,         1'b0, 1'b0, 32'h0000_0100};
      vecs[8] = '{1'b0, 5'd0,  32'h0,         32'h0,         3'b000, 1'b0, 32'h0,        1'b1, 32'h0,         32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,         32'h0,         32'h0,         1'b0, 1'b1, 32'hFFFF_FFFE};

      for (int i = 0; i < 9; i++) begin
         run_vec(vecs[i], i);
         step();
      end

      // Priority: exception, SRET and SEI together. The exception goes
      // first; the held SRET is taken on the return to IDLE.
      clear_src();
      exc_valid   = 1'b1;
      exc_cause   = 5'd3;
      exc_pc      = 32'h600;
      exc_tval    = 32'h11;
      sret_req    = 1'b1;
      irq_pending = 3'b100;
      boundary    = 1'b1;
      sie_q       = 1'b1;
      spie_q      = 1'b0;
      csr_sepc_q  = 32'h700;
      csr_stvec_q = 32'h2000_0000;
      #1;
      chk1("prio_accept", accept, 1'b1);
      step();
      exc_valid = 1'b0;
      step();
      chk1("prio_trap_we", trap_we, 1'b1);
      chk("prio_scause", scause_d, 32'h0000_0003);
      step();
      chk("prio_rpc", redirect_pc, 32'h2000_0000);
      finish_redirect();
      chk1("prio_sret_accept", accept, 1'b1);
      step();
      sret_req    = 1'b0;
      irq_pending = 3'b000;
      step();
      chk1("prio_ret_we", ret_we, 1'b1);
      chk1("prio_ret_trap_we", trap_we, 1'b0);
      step();
      chk("prio_ret_rpc", redirect_pc, 32'h0000_0700);
      finish_redirect();
      clear_src();
      step();

      // Drain: never drains, drains early, drains on the last count, at once.
      run_flush(-1, 16, 1, 15);
      run_flush(5, 6, 0, -1);
      run_flush(15, 16, 0, -1);
      run_flush(0, 1, 0, -1);

      // Backpressure: redirect held for 5 cycles with another request waiting.
      clear_src();
      pipe_drained = 1'b1;
      exc_valid    = 1'b1;
      exc_cause    = 5'd6;
      exc_pc       = 32'h900;
      exc_tval     = 32'h55;
      csr_stvec_q  = 32'h4000_0001;
      #1;
      chk1("bp_accept", accept, 1'b1);
      step();
      exc_valid = 1'b0;
      sret_req  = 1'b1;
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         chk1($sformatf("bp_rvalid%0d", i), redirect_valid, 1'b1);
         chk($sformatf("bp_rpc%0d", i), redirect_pc, 32'h4000_0000);
         chk1($sformatf("bp_no_accept%0d", i), accept, 1'b0);
         step();
      end
      sret_req = 1'b0;
      finish_redirect();
      chk1("bp_idle_rvalid", redirect_valid, 1'b0);
      chk1("bp_idle_busy", busy, 1'b0);

      // Reset in the middle of FLUSH.
      clear_src();
      pipe_drained = 1'b0;
      exc_valid    = 1'b1;
      exc_cause    = 5'd7;
      exc_pc       = 32'hA00;
      #1;
      chk1("rst_accept", accept, 1'b1);
      step();
      exc_valid = 1'b0;
      step();
      step();
      chk1("rst_in_flush", flush, 1'b1);
      rst = 1'b1;
      step();
      chk_all_zero("rst_mid");
      rst          = 1'b0;
      pipe_drained = 1'b1;
      strobes      = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (trap_we || ret_we) strobes++;
      end
      chk("rst_no_strobe", strobes, 0);
      chk1("rst_after_busy", busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Bound on the whole run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
      $fatal(1);
   end

endmodule
